// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU debug scan host.
package cpu_debug_scan_pkg;

   localparam int DEF_IR_WIDTH = 2;
   localparam int DEF_DR_WIDTH = 38;

   typedef enum logic [2:0] {
      IDLE,
      UIR,
      CDR,
      SDR,
      UDR,
      RTI,
      RESP
   } scan_state_t;

   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/cpu_debug_scan_tck_gen.sv
// TCK divider: toggles tck every TCK_DIV clk cycles while run is high, and
// flags the cycles in which tck goes high (rise_stb) or low (fall_stb).
module cpu_debug_scan_tck_gen #(
   parameter int TCK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tck,
   output logic rise_stb,
   output logic fall_stb
);

   logic [7:0] cnt;
   logic       term;

   assign term     = run && (cnt == 8'(TCK_DIV - 1));
   assign rise_stb = term && !tck;
   assign fall_stb = term && tck;

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (term) begin
         cnt <= '0;
         tck <= ~tck;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/cpu_debug_scan_host.sv
// Virtual-JTAG scan host: runs UIR/CDR/SDR/UDR/RTI for one command at a time.
// Optional IR cache (skips UIR on a repeated instruction): CPU_DEBUG_SCAN_HOST_IR_CACHE_EN.
module cpu_debug_scan_host
   import cpu_debug_scan_pkg::*;
#(
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int TCK_DIV  = 4,
   parameter int RTI_TCKS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

   scan_state_t         state;
   logic [DR_WIDTH-1:0] dr_q;
   logic [BW-1:0]       bit_cnt;
   logic [BW-1:0]       bit_nxt;
   logic [3:0]          rti_cnt;
   logic                run;
   logic                rise_stb;
   logic                fall_stb;
   logic                accept;
   logic                skip_uir;

   assign run       = (state != IDLE) && (state != RESP);
   assign cmd_ready = (state == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign bit_nxt   = bit_cnt + 1'b1;

`ifdef CPU_DEBUG_SCAN_HOST_IR_CACHE_EN
   logic                cache_valid;
   logic [IR_WIDTH-1:0] cache_ir;
   assign skip_uir = cache_valid && (cache_ir == cmd_ir);
`else
   assign skip_uir = 1'b0;
`endif

   cpu_debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .tck      (vji_tck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Drives move on fall strobes (tck going low); tdo/ir_out sampled on rise strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         dr_q       <= '0;
         bit_cnt    <= '0;
         rti_cnt    <= '0;
         rsp_valid  <= 1'b0;
         rsp_dr     <= '0;
         rsp_ir_out <= '0;
         vji_tdi    <= 1'b0;
         vji_ir_in  <= '0;
         vji_uir    <= 1'b0;
         vji_cdr    <= 1'b0;
         vji_sdr    <= 1'b0;
         vji_udr    <= 1'b0;
         vji_rti    <= 1'b0;
`ifdef CPU_DEBUG_SCAN_HOST_IR_CACHE_EN
         cache_valid <= 1'b0;
         cache_ir    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dr_q <= cmd_dr;
                  if (skip_uir) begin
                     state   <= CDR;
                     vji_cdr <= 1'b1;
                  end else begin
                     state     <= UIR;
                     vji_ir_in <= cmd_ir;
                     vji_uir   <= 1'b1;
`ifdef CPU_DEBUG_SCAN_HOST_IR_CACHE_EN
                     cache_valid <= 1'b1;
                     cache_ir    <= cmd_ir;
`endif
                  end
               end
            end
            UIR: begin
               if (fall_stb) begin
                  state   <= CDR;
                  vji_uir <= 1'b0;
                  vji_cdr <= 1'b1;
               end
            end
            CDR: begin
               if (fall_stb) begin
                  state   <= SDR;
                  vji_cdr <= 1'b0;
                  vji_sdr <= 1'b1;
                  bit_cnt <= '0;
                  vji_tdi <= dr_q[0];
               end
            end
            SDR: begin
               if (rise_stb) rsp_dr[bit_cnt] <= vji_tdo;
               if (fall_stb) begin
                  if (bit_cnt == BW'(DR_WIDTH - 1)) begin
                     state   <= UDR;
                     vji_sdr <= 1'b0;
                     vji_udr <= 1'b1;
                  end else begin
                     bit_cnt <= bit_nxt;
                     vji_tdi <= dr_q[bit_nxt];
                  end
               end
            end
            UDR: begin
               if (rise_stb) rsp_ir_out <= vji_ir_out;
               if (fall_stb) begin
                  state   <= RTI;
                  vji_udr <= 1'b0;
                  vji_rti <= 1'b1;
                  rti_cnt <= '0;
               end
            end
            RTI: begin
               if (fall_stb) begin
                  if (rti_cnt == 4'(RTI_TCKS - 1)) begin
                     state     <= RESP;
                     vji_rti   <= 1'b0;
                     rsp_valid <= 1'b1;
                  end else begin
                     rti_cnt <= rti_cnt + 4'd1;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_debug_scan_host.sv
// Directed bench for cpu_debug_scan_host with a behavioural tck-domain slave.
module tb_cpu_debug_scan_host;
   import cpu_debug_scan_pkg::*;

   localparam int IRW      = 2;
   localparam int DRW      = 38;
   localparam int TDIV     = 2;
   localparam int RTIT     = 2;
   localparam int LAT_FULL = 2 * TDIV * (3 + DRW + RTIT);
   localparam int LAT_SKIP = LAT_FULL - 2 * TDIV;

   logic           clk;
   logic           reset;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [IRW-1:0] cmd_ir;
   logic [DRW-1:0] cmd_dr;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [DRW-1:0] rsp_dr;
   logic [IRW-1:0] rsp_ir_out;
   logic           vji_tck, vji_tdi, vji_tdo;
   logic [IRW-1:0] vji_ir_in, vji_ir_out;
   logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

   cpu_debug_scan_host #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(TDIV), .RTI_TCKS(RTIT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
      .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave model: captures at CDR, shifts LSB-first in SDR, ir_out only during UDR
   logic [DRW-1:0] sr = '0;
   logic [DRW-1:0] slave_cap = '0;
   logic [IRW-1:0] slave_ir_out = '0;
   int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_ovl, n_tdi_bad;
   logic prev_tdi = 1'b0;

   assign vji_tdo    = sr[0];
   assign vji_ir_out = vji_udr ? slave_ir_out : '0;

   always @(posedge vji_tck) begin
      if (vji_uir) n_uir++;
      if (vji_cdr) n_cdr++;
      if (vji_sdr) n_sdr++;
      if (vji_udr) n_udr++;
      if (vji_rti) n_rti++;
      if (vji_cdr) sr <= slave_cap;
      else if (vji_sdr) sr <= {vji_tdi, sr[DRW-1:1]};
   end

   always @(negedge clk) begin
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_ovl++;
      if (vji_tdi !== prev_tdi && vji_tck) n_tdi_bad++;
      prev_tdi = vji_tdi;
   end

   // scoreboard bookkeeping
   int n_chk = 0;
   int n_pass = 0;
   bit mc_valid = 1'b0;
   logic [IRW-1:0] mc_ir = '0;

   typedef struct {
      logic [IRW-1:0] ir;
      logic [DRW-1:0] dr;
      logic [DRW-1:0] cap;
      logic [IRW-1:0] ir_out;
      logic [DRW-1:0] exp_rsp_dr;
      logic [IRW-1:0] exp_ir_out;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic clr_mon();
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_ovl = 0; n_tdi_bad = 0;
   endtask

   task automatic model_ir(input logic [IRW-1:0] ir, output bit skip);
`ifdef CPU_DEBUG_SCAN_HOST_IR_CACHE_EN
      skip = mc_valid && (mc_ir == ir);
`else
      skip = 1'b0;
`endif
      mc_valid = 1'b1;
      mc_ir    = ir;
   endtask

   task automatic issue(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, output bit ok);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ir    = ir;
      cmd_dr    = dr;
      n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         ok = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         clr_mon();
         ok = 1'b1;
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_row(input vec_t v);
      bit skip, ok;
      int lat;
      slave_cap    = v.cap;
      slave_ir_out = v.ir_out;
      model_ir(v.ir, skip);
      issue(v.ir, v.dr, ok);
      if (ok) begin
         wait_rsp(lat);
         chk("latency", 64'(lat), 64'(skip ? LAT_SKIP : LAT_FULL));
         chk("rsp_valid", 64'(rsp_valid), 64'd1);
         chk("rsp_dr", 64'(rsp_dr), 64'(v.exp_rsp_dr));
         chk("rsp_ir_out", 64'(rsp_ir_out), 64'(v.exp_ir_out));
         chk("slave_sr", 64'(sr), 64'(v.dr));
         chk("uir_tcks", 64'(n_uir), skip ? 64'd0 : 64'd1);
         chk("cdr_tcks", 64'(n_cdr), 64'd1);
         chk("sdr_tcks", 64'(n_sdr), 64'(DRW));
         chk("udr_tcks", 64'(n_udr), 64'd1);
         chk("rti_tcks", 64'(n_rti), 64'(RTIT));
         chk("strobe_overlap", 64'(n_ovl), 64'd0);
         chk("tdi_while_tck_high", 64'(n_tdi_bad), 64'd0);
         chk("ir_in_held", 64'(vji_ir_in), 64'(v.ir));
         chk("tck_low_in_resp", 64'(vji_tck), 64'd0);
         @(posedge clk);
         #1;
         chk("rsp_done", 64'(rsp_valid), 64'd0);
         chk("ready_after_rsp", 64'(cmd_ready), 64'd1);
      end
   endtask

   initial begin
      bit skip, ok;
      int lat, n, bad;
      logic [DRW-1:0] held;

      vecs[0] = '{2'b00, 38'h2A_5A5A_A5A5, 38'h15_0F0F_F0F0, 2'b00, 38'h15_0F0F_F0F0, 2'b00};
      vecs[1] = '{2'b11, 38'h00_0000_0001, 38'h20_0000_0000, 2'b11, 38'h20_0000_0000, 2'b11};
      vecs[2] = '{2'b10, 38'h12_3456_789A, 38'h2D_CBA9_8765, 2'b01, 38'h2D_CBA9_8765, 2'b01};
      vecs[3] = '{2'b10, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
      vecs[4] = '{2'b01, 38'h3F_FFFF_FFFE, 38'h00_0000_0003, 2'b11, 38'h00_0000_0003, 2'b11};

      reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
      clr_mon();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("ready_in_reset", 64'(cmd_ready), 64'd0);
      chk("vji_in_reset", 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 64'(cmd_ready), 64'd1);
      chk("rsp_valid_reset", 64'(rsp_valid), 64'd0);
      chk("rsp_dr_reset", 64'(rsp_dr), 64'd0);
      chk("rsp_ir_out_reset", 64'(rsp_ir_out), 64'd0);

      // table-driven transfers
      for (int i = 0; i < 5; i++) run_row(vecs[i]);

      // backpressure: response held while a second command waits
      rsp_ready    = 1'b0;
      slave_cap    = 38'h0A_AAAA_5555;
      slave_ir_out = 2'b10;
      model_ir(2'b00, skip);
      issue(2'b00, 38'h01_2345_6789, ok);
      if (ok) begin
         wait_rsp(lat);
         chk("bp_latency", 64'(lat), 64'(skip ? LAT_SKIP : LAT_FULL));
         chk("bp_rsp_dr", 64'(rsp_dr), 64'h0A_AAAA_5555);
         held      = rsp_dr;
         cmd_valid = 1'b1;
         cmd_ir    = 2'b11;
         cmd_dr    = 38'h3C_3C3C_3C3C;
         slave_cap = 38'h03_C3C3_C3C3;
         bad = 0;
         for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dr !== held || cmd_ready) bad++;
         end
         chk("bp_stable", 64'(bad), 64'd0);
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_handshake", 64'(rsp_valid), 64'd0);
         chk("bp_ready_next", 64'(cmd_ready), 64'd1);
         @(posedge clk);
         #1;
         chk("bp_second_accept", 64'(cmd_ready), 64'd0);
         cmd_valid = 1'b0;
         clr_mon();
         model_ir(2'b11, skip);
         wait_rsp(lat);
         chk("bp2_latency", 64'(lat), 64'(skip ? LAT_SKIP : LAT_FULL));
         chk("bp2_rsp_dr", 64'(rsp_dr), 64'h03_C3C3_C3C3);
         chk("bp2_slave_sr", 64'(sr), 64'h3C_3C3C_3C3C);
         @(posedge clk);
         #1;
      end

      // reset in the middle of SDR
      slave_cap = 38'h11_1111_1111;
      model_ir(2'b01, skip);
      issue(2'b01, 38'h1F_0000_FFFF, ok);
      if (ok) begin
         n = 0;
         while (n_sdr < 17 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("reached_bit17", 64'(n_sdr), 64'd17);
         reset = 1'b1;
         @(posedge clk);
         #1;
         chk("mid_reset_vji", 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
         chk("mid_reset_rsp", 64'(rsp_valid), 64'd0);
         @(negedge clk);
         reset    = 1'b0;
         mc_valid = 1'b0;
         #1;
         chk("mid_reset_idle", 64'(cmd_ready), 64'd1);
         bad = 0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid || vji_tck) bad++;
         end
         chk("no_rsp_after_abort", 64'(bad), 64'd0);
      end
      run_row(vecs[4]);
      run_row(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
